// File: rtl/fp_align_ctrl.sv
// Exponent-alignment sequencer for the FP adder: swaps operands by exponent, right-shifts the small mantissa.
// Optional ALIGN_BARREL_EN: whole shift done in the capture cycle instead of one bit per cycle.
module fp_align_ctrl #(
    parameter int unsigned EXP_SIZE  = 8,
    parameter int unsigned MANT_SIZE = 23
) (
    input  logic                          in_clk,
    input  logic                          in_rst_n,
    input  logic [EXP_SIZE+MANT_SIZE:0]   in_A,
    input  logic [EXP_SIZE+MANT_SIZE:0]   in_B,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [1:0]                    out_code,
    output logic                          out_swap,
    output logic                          out_sign_big,
    output logic                          out_sign_small,
    output logic [EXP_SIZE-1:0]           out_exp,
    output logic [MANT_SIZE+2:0]          out_mant_big,
    output logic [MANT_SIZE+2:0]          out_mant_small,
    output logic                          out_sticky
);

    localparam int unsigned W    = MANT_SIZE + 3;
    localparam int unsigned OP_W = 1 + EXP_SIZE + MANT_SIZE;

    localparam logic [1:0] CODE_EQUAL = 2'b00;
    localparam logic [1:0] CODE_SMALL = 2'b01;
    localparam logic [1:0] CODE_GREAT = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [1:0]            r_code;
    logic                  r_swap, r_sign_big, r_sign_small, r_sticky;
    logic [EXP_SIZE-1:0]   r_exp, r_cnt;
    logic [W-1:0]          r_mant_big, r_mant_small;

    logic [EXP_SIZE-1:0]   w_exp_a, w_exp_b, w_exp_big, w_exp_small, w_diff;
    logic [W-1:0]          w_ext_a, w_ext_b, w_ext_big, w_ext_small;
    logic [W-1:0]          w_cap_mant_small;
    logic [1:0]            w_code;
    logic                  w_swap, w_flush, w_cap_sticky, w_go_shift;
`ifdef ALIGN_BARREL_EN
    logic [W-1:0]          w_shifted, w_lost;
`endif

    // Operand unpack, compare and capture values for the accept cycle
    always_comb begin
        w_exp_a     = in_A[OP_W-2 -: EXP_SIZE];
        w_exp_b     = in_B[OP_W-2 -: EXP_SIZE];
        w_ext_a     = {(|w_exp_a), in_A[MANT_SIZE-1:0], 2'b00};
        w_ext_b     = {(|w_exp_b), in_B[MANT_SIZE-1:0], 2'b00};
        w_swap      = (w_exp_a < w_exp_b);
        w_code      = (w_exp_a == w_exp_b) ? CODE_EQUAL : (w_swap ? CODE_SMALL : CODE_GREAT);
        w_exp_big   = w_swap ? w_exp_b : w_exp_a;
        w_exp_small = w_swap ? w_exp_a : w_exp_b;
        w_ext_big   = w_swap ? w_ext_b : w_ext_a;
        w_ext_small = w_swap ? w_ext_a : w_ext_b;
        w_diff      = w_exp_big - w_exp_small;
        w_flush     = (32'(w_diff) >= 32'(W));
`ifdef ALIGN_BARREL_EN
        w_shifted   = w_ext_small >> w_diff;
        w_lost      = w_ext_small & ~({W{1'b1}} << w_diff);
`endif
        w_cap_mant_small = w_ext_small;
        w_cap_sticky     = 1'b0;
        w_go_shift       = 1'b0;
        if (w_flush) begin
            w_cap_mant_small = '0;
            w_cap_sticky     = |w_ext_small;
        end else if (w_diff != '0) begin
`ifdef ALIGN_BARREL_EN
            w_cap_mant_small = w_shifted;
            w_cap_sticky     = |w_lost;
`else
            w_go_shift       = 1'b1;
`endif
        end
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = w_go_shift ? S_SHIFT : S_DONE;
            S_SHIFT: if (r_cnt == EXP_SIZE'(1)) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Result registers: loaded on accept, shifted in SHIFT, held otherwise
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            r_code       <= '0;
            r_swap       <= 1'b0;
            r_sign_big   <= 1'b0;
            r_sign_small <= 1'b0;
            r_exp        <= '0;
            r_cnt        <= '0;
            r_mant_big   <= '0;
            r_mant_small <= '0;
            r_sticky     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_code       <= w_code;
                    r_swap       <= w_swap;
                    r_sign_big   <= w_swap ? in_B[OP_W-1] : in_A[OP_W-1];
                    r_sign_small <= w_swap ? in_A[OP_W-1] : in_B[OP_W-1];
                    r_exp        <= w_exp_big;
                    r_cnt        <= w_diff;
                    r_mant_big   <= w_ext_big;
                    r_mant_small <= w_cap_mant_small;
                    r_sticky     <= w_cap_sticky;
                end
                S_SHIFT: begin
                    r_sticky     <= r_sticky | r_mant_small[0];
                    r_mant_small <= r_mant_small >> 1;
                    r_cnt        <= r_cnt - EXP_SIZE'(1);
                end
                default: ;
            endcase
        end
    end

    assign out_code       = r_code;
    assign out_swap       = r_swap;
    assign out_sign_big   = r_sign_big;
    assign out_sign_small = r_sign_small;
    assign out_exp        = r_exp;
    assign out_mant_big   = r_mant_big;
    assign out_mant_small = r_mant_small;
    assign out_sticky     = r_sticky;

endmodule

// File: tb/tb_fp_align_ctrl.sv
// Self-checking bench for fp_align_ctrl: directed vector table, reset/backpressure sequences, random ops vs. arithmetic model.
module tb_fp_align_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_A, in_B;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  out_code;
    logic        out_swap, out_sign_big, out_sign_small, out_sticky;
    logic [7:0]  out_exp;
    logic [25:0] out_mant_big, out_mant_small;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]  code;
        logic        swap, sb, ss;
        logic [7:0]  e;
        logic [25:0] mb, ms;
        logic        st;
        int          lat;
    } res_t;

    typedef struct {
        logic [31:0] a, b;
        res_t        r;
    } vec_t;

    fp_align_ctrl #(.EXP_SIZE(8), .MANT_SIZE(23)) dut (
        .in_clk(clk), .in_rst_n(rst_n), .in_A(in_A), .in_B(in_B),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_swap(out_swap), .out_sign_big(out_sign_big),
        .out_sign_small(out_sign_small), .out_exp(out_exp), .out_mant_big(out_mant_big),
        .out_mant_small(out_mant_small), .out_sticky(out_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
        end
    endtask

    // Reference: plain integer arithmetic on the operand fields
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t   r;
        int     ea, eb, big_e, small_e, diff;
        longint xa, xb, xs, xl, p;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        xa = ((ea != 0 ? longint'(8388608) : longint'(0)) + longint'(a[22:0])) * 4;
        xb = ((eb != 0 ? longint'(8388608) : longint'(0)) + longint'(b[22:0])) * 4;
        r.code = (ea == eb) ? 2'b00 : ((ea < eb) ? 2'b01 : 2'b10);
        r.swap = (ea < eb);
        big_e   = r.swap ? eb : ea;
        small_e = r.swap ? ea : eb;
        xl      = r.swap ? xb : xa;
        xs      = r.swap ? xa : xb;
        r.sb    = r.swap ? b[31] : a[31];
        r.ss    = r.swap ? a[31] : b[31];
        r.e     = 8'(big_e);
        r.mb    = 26'(xl);
        diff    = big_e - small_e;
        if (diff >= 26) begin
            r.ms  = '0;
            r.st  = (xs != 0);
            r.lat = 1;
        end else begin
            p     = longint'(1) << diff;
            r.ms  = 26'(xs / p);
            r.st  = ((xs % p) != 0);
            r.lat = (diff == 0) ? 1 : 1 + diff;
        end
        return r;
    endfunction

    function automatic vec_t mkvec(input logic [31:0] a, input logic [31:0] b, input logic [1:0] code,
                                   input logic swap, input logic sb, input logic ss, input logic [7:0] e,
                                   input logic [25:0] mb, input logic [25:0] ms, input logic st, input int lat);
        vec_t v;
        v.a = a; v.b = b;
        v.r.code = code; v.r.swap = swap; v.r.sb = sb; v.r.ss = ss; v.r.e = e;
        v.r.mb = mb; v.r.ms = ms; v.r.st = st; v.r.lat = lat;
        return v;
    endfunction

    task automatic compare_result(input string tag, input res_t e, input int lat);
        check({tag, " code"},      64'(out_code),       64'(e.code));
        check({tag, " swap"},      64'(out_swap),       64'(e.swap));
        check({tag, " sign_big"},  64'(out_sign_big),   64'(e.sb));
        check({tag, " sign_small"},64'(out_sign_small), 64'(e.ss));
        check({tag, " exp"},       64'(out_exp),        64'(e.e));
        check({tag, " mant_big"},  64'(out_mant_big),   64'(e.mb));
        check({tag, " mant_small"},64'(out_mant_small), 64'(e.ms));
        check({tag, " sticky"},    64'(out_sticky),     64'(e.st));
        check({tag, " latency"},   64'(lat),            64'(e.lat));
        check({tag, " in_ready busy"}, 64'(in_ready),   64'(0));
    endtask

    // Called on a negedge just after the accept edge; returns cycles until out_valid
    task automatic wait_valid(input string tag, output int lat);
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check({tag, " out_valid timeout"}, 64'(0), 64'(1));
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input res_t e, input int hold);
        int lat;
        check({tag, " in_ready idle"}, 64'(in_ready), 64'(1));
        in_A = a; in_B = b; in_valid = 1'b1;
        @(negedge clk);
        in_A = $urandom; in_B = $urandom; in_valid = 1'($urandom);
        wait_valid(tag, lat);
        compare_result(tag, e, lat);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " held valid"},      64'(out_valid),      64'(1));
            check({tag, " held mant_small"}, 64'(out_mant_small), 64'(e.ms));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " released valid"}, 64'(out_valid), 64'(0));
        check({tag, " released ready"}, 64'(in_ready),  64'(1));
    endtask

    task automatic check_zero(input string tag);
        check({tag, " out_valid"},  64'(out_valid),      64'(0));
        check({tag, " code"},       64'(out_code),       64'(0));
        check({tag, " swap"},       64'(out_swap),       64'(0));
        check({tag, " signs"},      64'({out_sign_big, out_sign_small}), 64'(0));
        check({tag, " exp"},        64'(out_exp),        64'(0));
        check({tag, " mant_big"},   64'(out_mant_big),   64'(0));
        check({tag, " mant_small"}, 64'(out_mant_small), 64'(0));
        check({tag, " sticky"},     64'(out_sticky),     64'(0));
    endtask

    vec_t tbl[9];

    initial begin
        int          lat;
        int          ea, eb;
        logic [31:0] a, b, za, zb;
        res_t        rx, rz;

        tbl[0] = mkvec(32'h3F800000, 32'h40000000, 2'b01, 1, 0, 0, 8'h80, 26'h2000000, 26'h1000000, 0, 2);
        tbl[1] = mkvec(32'h3FC00000, 32'h3F800000, 2'b00, 0, 0, 0, 8'h7F, 26'h3000000, 26'h2000000, 0, 1);
        tbl[2] = mkvec(32'h41000000, 32'h3F800001, 2'b10, 0, 0, 0, 8'h82, 26'h2000000, 26'h0400000, 1, 4);
        tbl[3] = mkvec(32'h7F000000, 32'h3F800001, 2'b10, 0, 0, 0, 8'hFE, 26'h2000000, 26'h0000000, 1, 1);
        tbl[4] = mkvec(32'h00000001, 32'h00000000, 2'b00, 0, 0, 0, 8'h00, 26'h0000004, 26'h0000000, 0, 1);
        tbl[5] = mkvec(32'hC0000000, 32'h3F800000, 2'b10, 0, 1, 0, 8'h80, 26'h2000000, 26'h1000000, 0, 2);
        tbl[6] = mkvec(32'h4C000000, 32'h3F800003, 2'b10, 0, 0, 0, 8'h98, 26'h2000000, 26'h0000001, 1, 26);
        tbl[7] = mkvec(32'h4C800000, 32'h3F800000, 2'b10, 0, 0, 0, 8'h99, 26'h2000000, 26'h0000000, 1, 1);
        tbl[8] = mkvec(32'hBF800000, 32'h40800000, 2'b01, 1, 0, 1, 8'h81, 26'h2000000, 26'h0800000, 0, 3);

        rst_n = 1'b0; in_A = '0; in_B = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset in_ready", 64'(in_ready), 64'(1));
        check_zero("post-reset");

        foreach (tbl[i]) run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].r, i % 3);

        // Reset in the middle of a serial shift discards the operation
        in_A = 32'h41000000; in_B = 32'h3F800000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid-shift in_ready", 64'(in_ready), 64'(0));
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_zero("mid-shift reset");
        check("mid-shift reset in_ready", 64'(in_ready), 64'(1));
        repeat (6) begin
            @(negedge clk);
            check("after reset no valid", 64'(out_valid), 64'(0));
            check("after reset in_ready", 64'(in_ready),  64'(1));
        end

        // Backpressure: new operands presented while result is pending are ignored
        rx = model(32'h3F800000, 32'h40000000);
        in_A = 32'h3F800000; in_B = 32'h40000000; in_valid = 1'b1;
        @(negedge clk);
        in_A = 32'h40000000; in_B = 32'h3F800000;
        wait_valid("bp", lat);
        compare_result("bp", rx, lat);
        repeat (5) begin
            @(negedge clk);
            check("bp held valid",      64'(out_valid),      64'(1));
            check("bp held in_ready",   64'(in_ready),       64'(0));
            check("bp held code",       64'(out_code),       64'(rx.code));
            check("bp held mant_small", 64'(out_mant_small), 64'(rx.ms));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp release valid", 64'(out_valid), 64'(0));
        check("bp release ready", 64'(in_ready),  64'(1));
        za = 32'h41000000; zb = 32'h3F800001;
        rz = model(za, zb);
        in_A = za; in_B = zb;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid("bp next", lat);
        compare_result("bp next", rz, lat);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Random operands with nearby exponents so every path is hit
        for (int n = 0; n < 200; n++) begin
            ea = int'($urandom_range(255, 0));
            if ($urandom_range(9, 0) == 0) ea = 0;
            eb = ea + int'($urandom_range(60, 0)) - 30;
            if (eb < 0)   eb = 0;
            if (eb > 255) eb = 255;
            a = {1'($urandom), 8'(ea), 23'($urandom)};
            b = {1'($urandom), 8'(eb), 23'($urandom)};
            if ($urandom_range(3, 0) == 0) a[22:0] = '0;
            if ($urandom_range(3, 0) == 0) b[22:0] = '0;
            if ($urandom_range(1, 0) == 0) begin
                lat = int'(a); a = b; b = 32'(lat);
            end
            run_op($sformatf("rnd%0d a=%h b=%h", n, a, b), a, b, model(a, b), int'($urandom_range(2, 0)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
